// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: groups the command-buffer opcode, datapath handshakes and the
// decoded control lines between the sequencer and the datapath.
//   master: the sequencer (consumes opcode/handshakes, drives control lines)
//   slave : the datapath / command buffer side
interface ctrl_sequencer_if #(
   parameter int unsigned OPCODE_WIDTH = 8,
   parameter int unsigned ALU_OP_WIDTH = 3
);
   logic [OPCODE_WIDTH-1:0] opcode;
   logic                    alu_cmp_result;
   logic                    qclk_trig;
   logic                    sync_enable;
   logic                    fproc_ready;
   logic [ALU_OP_WIDTH-1:0] alu_opcode;
   logic                    alu_in0_sel;
   logic [1:0]              alu_in1_sel;
   logic                    reg_write_en;
   logic [1:0]              reg_write_sel;
   logic                    instr_ptr_en;
   logic                    instr_ptr_load_en;
   logic                    qclk_load_en;
   logic                    cstrobe_enable;
   logic                    sync_out_ready;
   logic                    fproc_out_ready;
   logic                    done;
   logic                    timeout_err;

   modport master (
      input  opcode, alu_cmp_result, qclk_trig, sync_enable, fproc_ready,
      output alu_opcode, alu_in0_sel, alu_in1_sel, reg_write_en, reg_write_sel,
             instr_ptr_en, instr_ptr_load_en, qclk_load_en, cstrobe_enable,
             sync_out_ready, fproc_out_ready, done, timeout_err
   );

   modport slave (
      output opcode, alu_cmp_result, qclk_trig, sync_enable, fproc_ready,
      input  alu_opcode, alu_in0_sel, alu_in1_sel, reg_write_en, reg_write_sel,
             instr_ptr_en, instr_ptr_load_en, qclk_load_en, cstrobe_enable,
             sync_out_ready, fproc_out_ready, done, timeout_err
   );
endinterface

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle control sequencer. Decodes the command-buffer opcode and
// drives ALU, register-file, instruction-pointer, qclk, pulse, sync and fproc controls,
// stretching instructions over memory latency, ALU latency and external handshakes.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   bus   - ctrl_sequencer_if.master: opcode + handshakes in, control lines out
module ctrl_sequencer #(
   parameter int unsigned OPCODE_WIDTH    = 8,
   parameter int unsigned ALU_OP_WIDTH    = 3,
   parameter int unsigned MEM_READ_CYCLES = 2,
   parameter int unsigned ALU_LATENCY     = 1,
   parameter int unsigned TIMEOUT_CYCLES  = 0
) (
   input  logic             clk,
   input  logic             reset,
   ctrl_sequencer_if.master bus
);
   localparam int unsigned ClsW = OPCODE_WIDTH - ALU_OP_WIDTH;

   localparam logic [ClsW-1:0] ClsPulseI     = ClsW'(1);
   localparam logic [ClsW-1:0] ClsRegWriteI  = ClsW'(2);
   localparam logic [ClsW-1:0] ClsRegIAlu    = ClsW'(3);
   localparam logic [ClsW-1:0] ClsRegAlu     = ClsW'(4);
   localparam logic [ClsW-1:0] ClsJumpI      = ClsW'(5);
   localparam logic [ClsW-1:0] ClsJumpCondI  = ClsW'(6);
   localparam logic [ClsW-1:0] ClsIncQclk    = ClsW'(7);
   localparam logic [ClsW-1:0] ClsIncQclkI   = ClsW'(8);
   localparam logic [ClsW-1:0] ClsSync       = ClsW'(9);
   localparam logic [ClsW-1:0] ClsFprocRead  = ClsW'(10);
   localparam logic [ClsW-1:0] ClsJumpFproc  = ClsW'(11);
   localparam logic [ClsW-1:0] ClsDone       = ClsW'(12);

   typedef enum logic [2:0] {
      StMemWait, StDecode, StPulseWait, StAluWait, StSyncWait, StFprocWait, StHalt
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;          // shared: mem wait, ALU wait and watchdog count
   logic        timeout_q, timeout_d;

   logic [ClsW-1:0] cls;
   logic            mem_last, alu_last, wd_expire;

   // Ungated decode; every output except alu_opcode is forced low while reset is high
   logic       alu_in0_sel_c;
   logic [1:0] alu_in1_sel_c;
   logic       reg_write_en_c;
   logic [1:0] reg_write_sel_c;
   logic       instr_ptr_en_c, instr_ptr_load_en_c, qclk_load_en_c, cstrobe_enable_c;
   logic       sync_out_ready_c, fproc_out_ready_c;

   assign cls            = bus.opcode[OPCODE_WIDTH-1:ALU_OP_WIDTH];
   assign bus.alu_opcode = bus.opcode[ALU_OP_WIDTH-1:0];
   assign mem_last       = (cnt_q == 32'(MEM_READ_CYCLES - 1));
   assign alu_last       = (cnt_q == 32'(ALU_LATENCY - 1));
   assign wd_expire      = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StMemWait;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d             = state_q;
      cnt_d               = cnt_q;
      timeout_d           = timeout_q;
      reg_write_en_c      = 1'b0;
      reg_write_sel_c     = 2'd0;
      instr_ptr_en_c      = 1'b0;
      instr_ptr_load_en_c = 1'b0;
      qclk_load_en_c      = 1'b0;
      cstrobe_enable_c    = 1'b0;
      sync_out_ready_c    = 1'b0;
      fproc_out_ready_c   = 1'b0;

      case (state_q)
         StMemWait: begin
            if (mem_last) begin
               state_d = StDecode;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         StDecode: begin
            // Any instruction that completes here falls back to MEM_WAIT
            state_d = StMemWait;
            cnt_d   = '0;
            case (cls)
               ClsPulseI: begin
                  if (bus.qclk_trig) begin
                     cstrobe_enable_c = 1'b1;
                     instr_ptr_en_c   = 1'b1;
                  end else begin
                     state_d = StPulseWait;
                  end
               end
               ClsRegWriteI: begin
                  reg_write_en_c = 1'b1;
                  instr_ptr_en_c = 1'b1;
               end
               ClsRegIAlu, ClsRegAlu, ClsJumpCondI, ClsIncQclk, ClsIncQclkI:
                  state_d = StAluWait;
               ClsJumpI: instr_ptr_load_en_c = 1'b1;
               ClsSync: begin
                  sync_out_ready_c = 1'b1;
                  if (bus.sync_enable) instr_ptr_en_c = 1'b1;
                  else state_d = StSyncWait;
               end
               ClsFprocRead, ClsJumpFproc: begin
                  // fproc_ready seen this cycle belongs to an older request
                  fproc_out_ready_c = 1'b1;
                  state_d           = StFprocWait;
               end
               ClsDone: state_d = StHalt;
               default: instr_ptr_en_c = 1'b1;
            endcase
         end

         StPulseWait: begin
            if (bus.qclk_trig) begin
               cstrobe_enable_c = 1'b1;
               instr_ptr_en_c   = 1'b1;
               state_d          = StMemWait;
               cnt_d            = '0;
            end
         end

         StAluWait: begin
            if (alu_last) begin
               state_d = StMemWait;
               cnt_d   = '0;
               case (cls)
                  ClsRegIAlu, ClsRegAlu: begin
                     reg_write_en_c  = 1'b1;
                     reg_write_sel_c = 2'd1;
                     instr_ptr_en_c  = 1'b1;
                  end
                  ClsIncQclk, ClsIncQclkI: begin
                     qclk_load_en_c = 1'b1;
                     instr_ptr_en_c = 1'b1;
                  end
                  // JUMP_COND_I and JUMP_FPROC
                  default: begin
                     if (bus.alu_cmp_result) instr_ptr_load_en_c = 1'b1;
                     else instr_ptr_en_c = 1'b1;
                  end
               endcase
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         StSyncWait: begin
            sync_out_ready_c = 1'b1;
            // Release has priority over a same-cycle watchdog expiry
            if (bus.sync_enable) begin
               instr_ptr_en_c = 1'b1;
               state_d        = StMemWait;
               cnt_d          = '0;
            end else if (wd_expire) begin
               timeout_d = 1'b1;
               state_d   = StHalt;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         StFprocWait: begin
            if (bus.fproc_ready) begin
               cnt_d = '0;
               if (cls == ClsJumpFproc) begin
                  state_d = StAluWait;
               end else begin
                  reg_write_en_c  = 1'b1;
                  reg_write_sel_c = 2'd2;
                  instr_ptr_en_c  = 1'b1;
                  state_d         = StMemWait;
               end
            end else if (wd_expire) begin
               timeout_d = 1'b1;
               state_d   = StHalt;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         default: ;  // StHalt: parked until reset
      endcase
   end

   // ALU input selects are held for the whole ALU instruction
   always_comb begin
      alu_in0_sel_c = 1'b0;
      alu_in1_sel_c = 2'd0;
      if (state_q == StDecode || state_q == StAluWait) begin
         case (cls)
            ClsRegAlu:   alu_in0_sel_c = 1'b1;
            ClsIncQclk: begin
               alu_in0_sel_c = 1'b1;
               alu_in1_sel_c = 2'd1;
            end
            ClsIncQclkI: alu_in1_sel_c = 2'd1;
            default: ;  // REG_I_ALU / JUMP_COND_I use cmd + reg
         endcase
      end
      if (state_q == StAluWait && cls == ClsJumpFproc) alu_in1_sel_c = 2'd2;
   end

   assign bus.alu_in0_sel       = alu_in0_sel_c & ~reset;
   assign bus.alu_in1_sel       = reset ? 2'd0 : alu_in1_sel_c;
   assign bus.reg_write_en      = reg_write_en_c & ~reset;
   assign bus.reg_write_sel     = reset ? 2'd0 : reg_write_sel_c;
   assign bus.instr_ptr_en      = instr_ptr_en_c & ~reset;
   assign bus.instr_ptr_load_en = instr_ptr_load_en_c & ~reset;
   assign bus.qclk_load_en      = qclk_load_en_c & ~reset;
   assign bus.cstrobe_enable    = cstrobe_enable_c & ~reset;
   assign bus.sync_out_ready    = sync_out_ready_c & ~reset;
   assign bus.fproc_out_ready   = fproc_out_ready_c & ~reset;
   assign bus.done              = (state_q == StHalt) & ~reset;
   assign bus.timeout_err       = timeout_q & ~reset;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed scoreboard bench for ctrl_sequencer. Stimulus pushes the
// expected strobe vector and cycle of each output event; a monitor pops and compares
// whenever the DUT raises a strobe. Cycle numbers count from the first cycle after reset.
module tb_ctrl_sequencer;
   localparam int unsigned OpW = 8;
   localparam int unsigned AluW = 3;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   base = 0;
   int   n_vec = 0;
   int   n_err = 0;

   typedef struct {
      int          cyc;
      logic [13:0] vec;
      string       name;
   } exp_t;
   exp_t sb_q[$];

   ctrl_sequencer_if #(.OPCODE_WIDTH(OpW), .ALU_OP_WIDTH(AluW)) bus ();

   ctrl_sequencer #(
      .OPCODE_WIDTH   (OpW),
      .ALU_OP_WIDTH   (AluW),
      .MEM_READ_CYCLES(2),
      .ALU_LATENCY    (3),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // {rwe, rsel[1:0], ipe, ipl, qload, cstrobe, fproc_req, done, tmo, sync_rdy, in0, in1[1:0]}
   function automatic logic [13:0] mk(input logic rwe, input logic [1:0] rsel,
                                      input logic ipe, input logic ipl, input logic ql,
                                      input logic cs, input logic fr, input logic dn,
                                      input logic to, input logic sr, input logic i0,
                                      input logic [1:0] i1);
      return {rwe, rsel, ipe, ipl, ql, cs, fr, dn, to, sr, i0, i1};
   endfunction

   function automatic logic [13:0] cur_vec();
      return {bus.reg_write_en, bus.reg_write_sel, bus.instr_ptr_en, bus.instr_ptr_load_en,
              bus.qclk_load_en, bus.cstrobe_enable, bus.fproc_out_ready, bus.done,
              bus.timeout_err, bus.sync_out_ready, bus.alu_in0_sel, bus.alu_in1_sel};
   endfunction

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
      n_vec++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, got, req);
      end
   endtask

   task automatic expect_ev(input int off, input logic [13:0] vec, input string name);
      exp_t e;
      e.cyc  = base + off;
      e.vec  = vec;
      e.name = name;
      sb_q.push_back(e);
   endtask

   task automatic monitor();
      logic done_prev = 1'b0;
      logic to_prev = 1'b0;
      logic ev;
      exp_t e;
      forever begin
         @(negedge clk);
         ev = bus.reg_write_en | bus.instr_ptr_en | bus.instr_ptr_load_en | bus.qclk_load_en |
              bus.cstrobe_enable | bus.fproc_out_ready | (bus.done & ~done_prev) |
              (bus.timeout_err & ~to_prev);
         if (ev) begin
            n_vec++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_event: cycle %0d got %b required no event",
                        cyc - base, cur_vec());
            end else begin
               e = sb_q.pop_front();
               if (e.cyc != cyc || e.vec !== cur_vec()) begin
                  n_err++;
                  $display("FAIL %s: got cycle %0d vec %b, required cycle %0d vec %b",
                           e.name, cyc - base, cur_vec(), e.cyc - base, e.vec);
               end
            end
         end
         done_prev = bus.done;
         to_prev   = bus.timeout_err;
      end
   endtask

   // One reset cycle with a new opcode; returns #1 into cycle 0
   task automatic start(input logic [7:0] op);
      @(posedge clk); #1;
      reset           = 1'b1;
      bus.opcode      = op;
      bus.qclk_trig   = 1'b0;
      bus.sync_enable = 1'b0;
      bus.fproc_ready = 1'b0;
      @(negedge clk);
      chk("reset_outputs_zero", 16'(cur_vec()), 16'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      base  = cyc;
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while (sb_q.size() != 0 && n < max_cyc) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: got %0d pending events required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   // PULSE_I with qclk_trig low stalls silently in PULSE_WAIT
   task automatic park();
      bus.opcode      = 8'h08;
      bus.qclk_trig   = 1'b0;
      bus.sync_enable = 1'b0;
      bus.fproc_ready = 1'b0;
   endtask

   initial begin
      int sync_cnt;
      reset              = 1'b1;
      bus.opcode         = 8'h08;
      bus.alu_cmp_result = 1'b0;
      bus.qclk_trig      = 1'b0;
      bus.sync_enable    = 1'b0;
      bus.fproc_ready    = 1'b0;
      fork
         monitor();
      join_none

      // REG_WRITE_I: quiet for two cycles, write+advance at cycle 2
      start(8'h10);
      expect_ev(2, mk(1, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0), "reg_write_i");
      @(negedge clk);
      chk("idle_cycle0", 16'(cur_vec()), 16'h0);
      @(negedge clk);
      chk("idle_cycle1", 16'(cur_vec()), 16'h0);
      drain(10); park();

      // JUMP_COND_I taken / not taken, resolved 3 cycles after DECODE
      bus.alu_cmp_result = 1'b1;
      start(8'h30);
      expect_ev(5, mk(0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0), "jump_cond_taken");
      drain(12); park();
      bus.alu_cmp_result = 1'b0;
      start(8'h33);
      chk("alu_opcode_pass", 16'(bus.alu_opcode), 16'd3);
      expect_ev(5, mk(0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0), "jump_cond_not_taken");
      drain(12); park();

      // REG_ALU, INC_QCLK_I, INC_QCLK
      start(8'h20);
      expect_ev(5, mk(1, 2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0), "reg_alu");
      drain(12); park();
      start(8'h40);
      expect_ev(5, mk(0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1), "inc_qclk_i");
      drain(12); park();
      start(8'h38);
      expect_ev(5, mk(0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 2'd1), "inc_qclk");
      drain(12); park();

      // PULSE_I: trigger low 5 cycles from DECODE, high at cycle 7
      start(8'h08);
      expect_ev(7, mk(0, 2'd0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'd0), "pulse_wait");
      repeat (7) begin @(posedge clk); #1; end
      bus.qclk_trig = 1'b1;
      @(posedge clk); #1;
      bus.qclk_trig = 1'b0;
      drain(5);
      // PULSE_I with trigger already high in DECODE
      start(8'h08);
      bus.qclk_trig = 1'b1;
      expect_ev(2, mk(0, 2'd0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'd0), "pulse_immediate");
      repeat (3) begin @(posedge clk); #1; end
      bus.qclk_trig = 1'b0;
      drain(5); park();

      // SYNC released 4 cycles after DECODE
      start(8'h48);
      expect_ev(6, mk(0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0), "sync_release");
      sync_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         bus.sync_enable = (k == 6);
         if (k == 7) park();
         @(negedge clk);
         if (bus.sync_out_ready) sync_cnt++;
         @(posedge clk); #1;
      end
      chk("sync_ready_cycles", 16'(sync_cnt), 16'd5);
      drain(5);

      // JUMP_FPROC: request, release at cycle 4, ALU cycles 5..7, taken
      bus.alu_cmp_result = 1'b1;
      start(8'h58);
      expect_ev(2, mk(0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0), "jump_fproc_req");
      expect_ev(7, mk(0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd2), "jump_fproc_taken");
      repeat (4) begin @(posedge clk); #1; end
      bus.fproc_ready = 1'b1;
      @(posedge clk); #1;
      bus.fproc_ready = 1'b0;
      drain(10); park();
      bus.alu_cmp_result = 1'b0;

      // FPROC_READ: fproc_ready during DECODE ignored, accepted at cycle 4
      start(8'h50);
      expect_ev(2, mk(0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0), "fproc_req");
      expect_ev(4, mk(1, 2'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0), "fproc_read");
      repeat (2) begin @(posedge clk); #1; end
      bus.fproc_ready = 1'b1;
      @(posedge clk); #1;
      bus.fproc_ready = 1'b0;
      @(posedge clk); #1;
      bus.fproc_ready = 1'b1;
      @(posedge clk); #1;
      bus.fproc_ready = 1'b0;
      drain(5); park();

      // FPROC_READ watchdog: 8 wait cycles (3..10), HALT with timeout at 11
      start(8'h50);
      expect_ev(2, mk(0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0), "fproc_req_to");
      expect_ev(11, mk(0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'd0), "fproc_timeout");
      drain(20);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("timeout_sticky", 16'({bus.done, bus.timeout_err}), 16'b11);

      // Reset mid fproc wait, then restart cleanly with REG_WRITE_I
      start(8'h50);
      expect_ev(2, mk(0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0), "fproc_req_rst");
      drain(6);
      repeat (2) begin @(posedge clk); #1; end
      start(8'h10);
      expect_ev(2, mk(1, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0), "restart_after_reset");
      drain(10); park();
      repeat (12) @(posedge clk);

      // DONE: halts at cycle 3, later opcodes ignored
      start(8'h60);
      expect_ev(3, mk(0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0), "done");
      drain(10);
      bus.opcode = 8'h10;
      repeat (8) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("halt_quiet", 16'(cur_vec()), 16'(mk(0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0)));

      @(posedge clk); #1;
      chk("scoreboard_empty", 16'(sb_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
